shift_right_unit: RTL and testbench

32-bit registered right-shift unit for the CPU datapath ALU. It implements the SHR (logical), SHRA (arithmetic) and ROR (rotate) operations. The unit takes a 32-bit operand and a 32-bit shift amount and returns the shifted result one clock later with a valid flag. It is a 5-stage barrel shifter (shifts of 1/2/4/8/16) followed by an output register.

---
 rtl/shift_right_unit.sv | 46 ++++
 tb/tb_shift_right_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/shift_right_unit.sv
// shift_right_unit: registered 32-bit logical/arithmetic/rotate right barrel shifter
module shift_right_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [31:0] shift_amount,
    input  logic [1:0]  op,
    input  logic        in_valid,
    output logic [31:0] data_out,
    output logic        out_valid
);
    logic        rot;
    logic        fill;
    logic        oor;
    logic [31:0] stage [0:5];
    logic [31:0] result;

    assign rot  = op == 2'b10;
    assign fill = op == 2'b01 && data_in[31];
    assign oor  = |shift_amount[31:5];
    assign stage[0] = data_in;

    for (genvar k = 0; k < 5; k++) begin : g_stage
        localparam int N = 1 << k;
        assign stage[k+1] = !shift_amount[k] ? stage[k] :
                            rot ? {stage[k][N-1:0], stage[k][31:N]} :
                                  {{N{fill}}, stage[k][31:N]};
    end

    // Amounts of 32 or more saturate to the fill pattern except for rotate, which wraps mod 32
    always_comb begin
        result = (oor && !rot) ? {32{fill}} : stage[5];
    end

    // Output register: capture on in_valid, hold otherwise; reset wins over a same-edge capture
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= 32'h0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                data_out <= result;
        end
    end
endmodule

// File: tb/tb_shift_right_unit.sv
// tb_shift_right_unit: directed vectors with hand-computed results for shift_right_unit
module tb_shift_right_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = 32'h0;
    logic [31:0] shift_amount = 32'h0;
    logic [1:0]  op = 2'b00;
    logic        in_valid = 1'b0;
    logic [31:0] data_out;
    logic        out_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] d;
        logic [31:0] a;
        logic [1:0]  o;
        logic [31:0] e;
    } vec_t;

    vec_t vecs [] = '{
        '{32'h00000005, 32'd3,        2'b00, 32'h00000000},
        '{32'h00000006, 32'd1,        2'b00, 32'h00000003},
        '{32'h80000000, 32'd4,        2'b01, 32'hF8000000},
        '{32'h80000000, 32'd40,       2'b01, 32'hFFFFFFFF},
        '{32'h7FFFFFFF, 32'd31,       2'b01, 32'h00000000},
        '{32'h00000001, 32'd1,        2'b10, 32'h80000000},
        '{32'h00000001, 32'd32,       2'b10, 32'h00000001},
        '{32'h00000001, 32'd36,       2'b10, 32'h10000000},
        '{32'hDEADBEEF, 32'd0,        2'b00, 32'hDEADBEEF},
        '{32'hDEADBEEF, 32'd31,       2'b00, 32'h00000001},
        '{32'hDEADBEEF, 32'd32,       2'b00, 32'h00000000},
        '{32'hDEADBEEF, 32'hFFFFFFFF, 2'b00, 32'h00000000},
        '{32'hDEADBEEF, 32'd4,        2'b11, 32'h0DEADBEE},
        '{32'hDEADBEEF, 32'd8,        2'b10, 32'hEFDEADBE},
        '{32'hDEADBEEF, 32'd4,        2'b01, 32'hFDEADBEE},
        '{32'h12345678, 32'd40,       2'b01, 32'h00000000},
        '{32'hFFFFFFFF, 32'd16,       2'b00, 32'h0000FFFF},
        '{32'h12345678, 32'd16,       2'b10, 32'h56781234},
        '{32'h80000000, 32'd0,        2'b01, 32'h80000000},
        '{32'h80000001, 32'd31,       2'b10, 32'h00000003},
        '{32'hF0000000, 32'h00010000, 2'b01, 32'hFFFFFFFF},
        '{32'hF0000000, 32'h00010001, 2'b10, 32'h78000000}
    };

    shift_right_unit dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .shift_amount(shift_amount),
        .op(op),
        .in_valid(in_valid),
        .data_out(data_out),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        data_in = 32'hFFFFFFFF;
        shift_amount = 32'd0;
        op = 2'b00;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_data", data_out, 32'h0);
            check("rst_valid", {31'b0, out_valid}, 32'h1 & 32'h0);
        end
        rst = 1'b0;
        step();
        check("post_rst_data", data_out, 32'hFFFFFFFF);
        check("post_rst_valid", {31'b0, out_valid}, 32'h1);

        foreach (vecs[i]) begin
            data_in = vecs[i].d;
            shift_amount = vecs[i].a;
            op = vecs[i].o;
            in_valid = 1'b1;
            step();
            check($sformatf("vec%0d_data", i), data_out, vecs[i].e);
            check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'h1);
        end

        in_valid = 1'b0;
        data_in = 32'h0BADF00D;
        shift_amount = 32'd0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("idle_valid", {31'b0, out_valid}, 32'h0);
            check("idle_hold", data_out, 32'h78000000);
        end

        in_valid = 1'b1;
        rst = 1'b1;
        step();
        check("midrst_data", data_out, 32'h0);
        check("midrst_valid", {31'b0, out_valid}, 32'h0);
        rst = 1'b0;
        data_in = 32'h00000040;
        shift_amount = 32'd2;
        op = 2'b01;
        step();
        check("after_midrst_data", data_out, 32'h00000010);
        check("after_midrst_valid", {31'b0, out_valid}, 32'h1);
        in_valid = 1'b0;
        step();
        check("final_valid", {31'b0, out_valid}, 32'h0);
        check("final_hold", data_out, 32'h00000010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
